// File: rtl/aud_pkg.sv
// Shared definitions for the audio recorder and the playback DSP.
//   ADDR_W / DATA_W   SRAM address and sample widths
//   ADDR_FIRST        first sample address of a recording
//   ADDR_LAST         last usable address; writing here ends the recording
//   aud_state_t       recorder FSM states
package aud_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_FIRST = 20'd1;
    localparam logic [ADDR_W-1:0] ADDR_LAST  = 20'hFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LRC,
        SKIP,
        SHIFT,
        WRITE,
        PAUSE
    } aud_state_t;

endpackage

// File: rtl/aud_edge_sync.sv
// Two-flop synchronizer plus history flop with rise/fall detection.
//   i_clk   system clock
//   i_rst   synchronous active-high reset
//   i_sig   asynchronous input
//   o_rise  one-cycle pulse on a synchronized 0->1 transition
//   o_fall  one-cycle pulse on a synchronized 1->0 transition
module aud_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic sync_1;
    logic sync_2;
    logic hist;

    // Reset loads the live input into every stage so leaving reset
    // never produces a spurious edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_1 <= i_sig;
            sync_2 <= i_sig;
            hist   <= i_sig;
        end else begin
            sync_1 <= i_sig;
            sync_2 <= sync_1;
            hist   <= sync_2;
        end
    end

    assign o_rise = sync_2 & ~hist;
    assign o_fall = ~sync_2 & hist;

endmodule

// File: rtl/aud_recorder.sv
// I2S left-channel recorder writing 16-bit samples to SRAM.
//   i_clk, i_rst          system clock, synchronous active-high reset
//   i_start/i_pause/i_stop recording controls (stop > pause > start)
//   i_bclk, i_adclrck     asynchronous codec clocks
//   i_adcdat              codec serial data, MSB first
//   o_address, o_data     SRAM write address/data, held between writes
//   o_we                  one-cycle write strobe per sample
//   o_end_addr            address of the last sample written
//   o_finished            one-cycle pulse when a recording ends
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | not recording, waiting for i_start
// WAIT_LRC | waiting for LRC fall (start of a left frame)
// SKIP     | waiting out the I2S one-bit delay
// SHIFT    | shifting 16 left-channel bits on BCLK rises
// WRITE    | o_we high for the assembled sample
// PAUSE    | recording held, i_start resumes at the same address
module aud_recorder
    import aud_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_bclk,
    input  logic              i_adclrck,
    input  logic              i_adcdat,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic              o_finished
);

    localparam logic [3:0] BIT_LAST = 4'(DATA_W - 1);

    logic bclk_rise;
    logic unused_bclk_fall;
    logic unused_lrc_rise;
    logic lrc_fall;

    aud_edge_sync u_bclk_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sig  (i_bclk),
        .o_rise (bclk_rise),
        .o_fall (unused_bclk_fall)
    );

    aud_edge_sync u_lrc_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sig  (i_adclrck),
        .o_rise (unused_lrc_rise),
        .o_fall (lrc_fall)
    );

    aud_state_t        state;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] shift_reg;
    logic [3:0]        bit_cnt;
    logic              pause_pend;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            next_addr  <= '0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            pause_pend <= 1'b0;
            o_address  <= '0;
            o_data     <= '0;
            o_we       <= 1'b0;
            o_end_addr <= '0;
            o_finished <= 1'b0;
        end else begin
            o_we       <= 1'b0;
            o_finished <= 1'b0;

            if (i_stop && state != IDLE) begin
                state      <= IDLE;
                o_finished <= 1'b1;
                shift_reg  <= '0;
                bit_cnt    <= '0;
                pause_pend <= 1'b0;
                // A stop in WRITE lands after the strobe already went out,
                // so that sample counts as written.
                if (state == WRITE) begin
                    o_end_addr <= o_address;
                end
            end else begin
                if (i_pause && (state inside {WAIT_LRC, SKIP, SHIFT, WRITE})) begin
                    pause_pend <= 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (i_start) begin
                            next_addr  <= ADDR_FIRST;
                            o_end_addr <= '0;
                            pause_pend <= 1'b0;
                            state      <= WAIT_LRC;
                        end
                    end

                    WAIT_LRC: begin
                        if (lrc_fall) begin
                            state <= SKIP;
                        end
                    end

                    SKIP: begin
                        if (bclk_rise) begin
                            bit_cnt <= '0;
                            state   <= SHIFT;
                        end
                    end

                    SHIFT: begin
                        if (bclk_rise) begin
                            shift_reg <= {shift_reg[DATA_W-2:0], i_adcdat};
                            if (bit_cnt == BIT_LAST) begin
                                o_we      <= 1'b1;
                                o_data    <= {shift_reg[DATA_W-2:0], i_adcdat};
                                o_address <= next_addr;
                                state     <= WRITE;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    WRITE: begin
                        o_end_addr <= o_address;
                        // Full takes precedence over a pending pause: resuming
                        // after the last address would otherwise wrap to 0.
                        if (o_address == ADDR_LAST) begin
                            o_finished <= 1'b1;
                            pause_pend <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            next_addr <= next_addr + 20'd1;
                            if (pause_pend || i_pause) begin
                                state <= PAUSE;
                            end else begin
                                state <= WAIT_LRC;
                            end
                        end
                    end

                    PAUSE: begin
                        if (i_start && !i_pause) begin
                            pause_pend <= 1'b0;
                            state      <= WAIT_LRC;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aud_recorder.sv
module tb_aud_recorder;
    import aud_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_pause = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_bclk = 1'b0;
    logic        i_adclrck = 1'b1;
    logic        i_adcdat = 1'b0;
    logic [19:0] o_address;
    logic [15:0] o_data;
    logic        o_we;
    logic [19:0] o_end_addr;
    logic        o_finished;

    always #5 i_clk = ~i_clk;

    aud_recorder dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_pause    (i_pause),
        .i_stop     (i_stop),
        .i_bclk     (i_bclk),
        .i_adclrck  (i_adclrck),
        .i_adcdat   (i_adcdat),
        .o_address  (o_address),
        .o_data     (o_data),
        .o_we       (o_we),
        .o_end_addr (o_end_addr),
        .o_finished (o_finished)
    );

    int tests = 0;
    int fails = 0;

    logic [35:0] wq[$];
    int          fin_cycles = 0;
    int          fin_pulses = 0;
    logic        fin_prev = 1'b0;

    // Observe writes and finished pulses away from the active edge.
    always @(negedge i_clk) begin
        if (o_we) wq.push_back({o_address, o_data});
        if (o_finished) fin_cycles++;
        if (o_finished && !fin_prev) fin_pulses++;
        fin_prev = o_finished;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
    endtask

    // Expect exactly one queued write {addr, data}.
    task automatic expect_write(input string name, input logic [19:0] addr, input logic [15:0] data);
        logic [35:0] w;
        chk({name, "_count"}, 64'(wq.size()), 64'd1);
        if (wq.size() > 0) begin
            w = wq.pop_front();
            chk({name, "_addr"}, 64'(w[35:16]), 64'(addr));
            chk({name, "_data"}, 64'(w[15:0]), 64'(data));
        end
        wq.delete();
    endtask

    // One I2S frame: 24 BCLKs per channel, slot 0 is the one-bit delay,
    // slots 1..16 carry the word MSB first. ctl {rst,start,stop,pause}
    // is pulsed for one cycle at the BCLK rise carrying left bit ctl_bit.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int ctl_bit, input logic [3:0] ctl);
        for (int s = 0; s < 48; s++) begin
            logic        lr;
            int          slot;
            logic [15:0] w;
            lr   = (s >= 24);
            slot = s % 24;
            w    = lr ? r : l;
            i_bclk    = 1'b0;
            i_adclrck = lr;
            i_adcdat  = (slot >= 1 && slot <= 16) ? w[16 - slot] : 1'b0;
            repeat (4) @(negedge i_clk);
            i_bclk = 1'b1;
            if (!lr && (slot - 1) == ctl_bit) begin
                i_pause = ctl[0];
                i_stop  = ctl[1];
                i_start = ctl[2];
                i_rst   = ctl[3];
            end
            @(negedge i_clk);
            if (i_rst) begin
                chk("rst_mid_we", 64'(o_we), 64'd0);
                chk("rst_mid_addr", 64'(o_address), 64'd0);
                chk("rst_mid_data", 64'(o_data), 64'd0);
                chk("rst_mid_end", 64'(o_end_addr), 64'd0);
                chk("rst_mid_fin", 64'(o_finished), 64'd0);
            end
            i_pause = 1'b0;
            i_stop  = 1'b0;
            i_start = 1'b0;
            i_rst   = 1'b0;
            repeat (3) @(negedge i_clk);
        end
    endtask

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [19:0] addr;
        logic [15:0] data;
    } vec_t;

    initial begin
        vec_t vt[3];
        int   fin0;
        int   fc0;
        int   exp_addr;
        bit   active;
        bit   paused;

        vt[0] = '{16'h8001, 16'h5555, 20'd1, 16'h8001};
        vt[1] = '{16'h1234, 16'h5555, 20'd2, 16'h1234};
        vt[2] = '{16'hFFFF, 16'h5555, 20'd3, 16'hFFFF};

        // Reset state
        repeat (3) @(negedge i_clk);
        chk("reset_we", 64'(o_we), 64'd0);
        chk("reset_addr", 64'(o_address), 64'd0);
        chk("reset_data", 64'(o_data), 64'd0);
        chk("reset_end", 64'(o_end_addr), 64'd0);
        chk("reset_fin", 64'(o_finished), 64'd0);
        chk("reset_state", 64'(dut.state), 64'(IDLE));
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);

        // Three left words, right channel ignored
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            send_frame(vt[i].l, vt[i].r, -1, 4'b0000);
            expect_write($sformatf("tbl%0d", i), vt[i].addr, vt[i].data);
        end
        chk("tbl_end_addr", 64'(o_end_addr), 64'd3);
        chk("tbl_hold_addr", 64'(o_address), 64'd3);
        chk("tbl_hold_data", 64'(o_data), 64'hFFFF);

        // Stop from WAIT_LRC, then fresh recording with a pause
        fin0 = fin_pulses;
        i_stop = 1'b1;
        @(negedge i_clk);
        i_stop = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("stop_idle_fin", 64'(fin_pulses - fin0), 64'd1);

        pulse_start();
        send_frame(16'hA5A5, 16'h0F0F, -1, 4'b0000);
        expect_write("pz1", 20'd1, 16'hA5A5);
        send_frame(16'h3C3C, 16'h0F0F, 7, 4'b0001);
        expect_write("pz2", 20'd2, 16'h3C3C);
        for (int i = 0; i < 10; i++) send_frame(16'(16'h1111 * i), 16'h2222, -1, 4'b0000);
        chk("pz_no_we", 64'(wq.size()), 64'd0);
        wq.delete();
        chk("pz_state", 64'(dut.state), 64'(PAUSE));
        pulse_start();
        send_frame(16'h7E57, 16'h0F0F, -1, 4'b0000);
        expect_write("pz3", 20'd3, 16'h7E57);

        // Stop during bit 9 of sample 4
        fin0 = fin_pulses;
        fc0  = fin_cycles;
        send_frame(16'hBEEF, 16'h0F0F, 9, 4'b0010);
        chk("stop_no_we", 64'(wq.size()), 64'd0);
        wq.delete();
        chk("stop_fin_pulses", 64'(fin_pulses - fin0), 64'd1);
        chk("stop_fin_cycles", 64'(fin_cycles - fc0), 64'd1);
        chk("stop_end_addr", 64'(o_end_addr), 64'd3);
        chk("stop_state", 64'(dut.state), 64'(IDLE));

        // Full memory ends the recording
        pulse_start();
        force dut.next_addr = 20'hFFFFE;
        @(negedge i_clk);
        release dut.next_addr;
        @(negedge i_clk);
        fin0 = fin_pulses;
        send_frame(16'h0102, 16'h0F0F, -1, 4'b0000);
        expect_write("full1", 20'hFFFFE, 16'h0102);
        chk("full1_fin", 64'(fin_pulses - fin0), 64'd0);
        send_frame(16'h0304, 16'h0F0F, -1, 4'b0000);
        expect_write("full2", 20'hFFFFF, 16'h0304);
        chk("full2_fin", 64'(fin_pulses - fin0), 64'd1);
        send_frame(16'h0506, 16'h0F0F, -1, 4'b0000);
        chk("full_no_we", 64'(wq.size()), 64'd0);
        wq.delete();
        chk("full_end_addr", 64'(o_end_addr), 64'hFFFFF);
        chk("full_state", 64'(dut.state), 64'(IDLE));

        // Stop, pause and start together in SHIFT: stop wins
        pulse_start();
        send_frame(16'h4242, 16'h0F0F, -1, 4'b0000);
        expect_write("prio1", 20'd1, 16'h4242);
        fin0 = fin_pulses;
        send_frame(16'h9999, 16'h0F0F, 5, 4'b0111);
        chk("prio_no_we", 64'(wq.size()), 64'd0);
        wq.delete();
        chk("prio_fin", 64'(fin_pulses - fin0), 64'd1);
        chk("prio_state", 64'(dut.state), 64'(IDLE));

        // Reset mid-SHIFT
        pulse_start();
        fin0 = fin_pulses;
        send_frame(16'h6666, 16'h0F0F, 8, 4'b1000);
        chk("rst_no_we", 64'(wq.size()), 64'd0);
        wq.delete();
        chk("rst_no_fin", 64'(fin_pulses - fin0), 64'd0);
        chk("rst_state", 64'(dut.state), 64'(IDLE));

        // Random frames with random pauses and resumes against a frame-level model
        pulse_start();
        exp_addr = 1;
        active   = 1'b1;
        paused   = 1'b0;
        for (int f = 0; f < 30; f++) begin
            logic [15:0] l;
            logic [15:0] r;
            int          pb;
            l  = 16'($urandom);
            r  = 16'($urandom);
            if (paused && $urandom_range(0, 2) == 0) begin
                pulse_start();
                paused = 1'b0;
                active = 1'b1;
            end
            pb = -1;
            if (active && $urandom_range(0, 4) == 0) pb = int'($urandom_range(0, 15));
            send_frame(l, r, pb, (pb >= 0) ? 4'b0001 : 4'b0000);
            if (active) begin
                expect_write($sformatf("rnd%0d", f), 20'(exp_addr), l);
                exp_addr++;
                if (pb >= 0) begin
                    active = 1'b0;
                    paused = 1'b1;
                end
            end else begin
                chk($sformatf("rnd%0d_idle", f), 64'(wq.size()), 64'd0);
                wq.delete();
            end
        end
        chk("rnd_end_addr", 64'(o_end_addr), 64'(exp_addr - 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
